pusch_pingpong_buffer: RTL

- Dual-bank (ping-pong) symbol store directly downstream of the modulation mapper.
- Captures mapper I/Q symbols into one bank by write address while the other bank streams out, in address order, to the next PUSCH stage (transform precoding) over a valid/ready handshake.
- A bank is committed and the banks swap on the mapper's PINGPONG_SWITCH indication.

---
 rtl/pusch_pingpong_buffer_if.sv | 30 +++
 rtl/pusch_pingpong_buffer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pusch_pingpong_buffer_if.sv
// pusch_pingpong_buffer_if: mapper write bus and downstream read stream of the PUSCH ping-pong buffer
//   write side : write_enable, Wr_addr, Wr_I, Wr_Q, PINGPONG_SWITCH (mapper -> buffer)
//   read side  : Rd_Valid, Rd_I, Rd_Q, Rd_Index, Rd_First, Rd_Last (buffer -> precoder), Rd_Ready (precoder -> buffer)
//   master     : producer/consumer view (mapper + transform precoder, or a testbench)
//   slave      : buffer view
interface pusch_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11
);
  logic                         write_enable;
  logic [ADDR_WIDTH-1:0]        Wr_addr;
  logic signed [DATA_WIDTH-1:0] Wr_I;
  logic signed [DATA_WIDTH-1:0] Wr_Q;
  logic                         PINGPONG_SWITCH;
  logic                         Rd_Ready;
  logic                         Rd_Valid;
  logic signed [DATA_WIDTH-1:0] Rd_I;
  logic signed [DATA_WIDTH-1:0] Rd_Q;
  logic [ADDR_WIDTH-1:0]        Rd_Index;
  logic                         Rd_First;
  logic                         Rd_Last;
  modport master (
    output write_enable, Wr_addr, Wr_I, Wr_Q, PINGPONG_SWITCH, Rd_Ready,
    input  Rd_Valid, Rd_I, Rd_Q, Rd_Index, Rd_First, Rd_Last
  );
  modport slave (
    input  write_enable, Wr_addr, Wr_I, Wr_Q, PINGPONG_SWITCH, Rd_Ready,
    output Rd_Valid, Rd_I, Rd_Q, Rd_Index, Rd_First, Rd_Last
  );
endinterface

// File: rtl/pusch_pingpong_buffer.sv
// pusch_pingpong_buffer: dual-bank I/Q symbol store between modulation mapper and transform precoding
//   CLK_PP     : clock
//   RST_PP     : asynchronous active-low reset (RAM contents kept, both banks discarded)
//   bus        : mapper write bus + valid/ready read stream (pusch_pingpong_buffer_if.slave)
//   Wr_Bank    : bank currently selected for writing
//   Bank_Full  : per-bank committed-and-unread flags
//   Overflow   : sticky, a commit was refused because no free bank remained
//   Addr_Err   : sticky, a write arrived with address >= DEPTH
// Optional build macro PP_RB_PAD_EN: read frames are zero-padded up to a multiple of 12 samples.
module pusch_pingpong_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                   CLK_PP,
  input  logic                   RST_PP,
  pusch_pingpong_buffer_if.slave bus,
  output logic                   Wr_Bank,
  output logic [1:0]             Bank_Full,
  output logic                   Overflow,
  output logic                   Addr_Err
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEP = LW'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
  state_t state;
  logic [2*DATA_WIDTH-1:0] mem [0:2*DEPTH-1];
  logic [2*DATA_WIDTH-1:0] rdata;
  logic [LW-1:0] wr_len, len_eff, rd_len, rd_end, idx, nxt, rd_ma, wr_ma;
  logic [LW-1:0] frame_len [2];
  logic sw_q, sw_rise, wr_ok, wr_store, accept, release_rd, wb_busy, commit, refuse;
  logic rd_en, rd_bank, pad_q, rd_valid, rd_first, rd_last;

  function automatic logic [LW-1:0] round12(input logic [LW-1:0] n);
`ifdef PP_RB_PAD_EN
    round12 = ((n + LW'(11)) / LW'(12)) * LW'(12);
`else
    round12 = n;
`endif
  endfunction

  assign wr_ok    = bus.write_enable && ({1'b0, bus.Wr_addr} < DEP);
  // a bank still holding an unread frame is never overwritten; its length is still tracked
  // so that the following commit edge is seen and refused
  assign wr_store = wr_ok && !Bank_Full[Wr_Bank];
  assign wr_ma    = {1'b0, bus.Wr_addr} + (Wr_Bank ? DEP : '0);
  // same-cycle write belongs to the bank being committed
  assign len_eff  = (wr_ok && {1'b0, bus.Wr_addr} >= wr_len) ? {1'b0, bus.Wr_addr} + LW'(1) : wr_len;
  assign sw_rise  = bus.PINGPONG_SWITCH && !sw_q;
  assign accept   = rd_valid && bus.Rd_Ready;
  assign release_rd = accept && rd_last;
  // both banks occupied; a release of the write bank in this very cycle frees it (release wins)
  assign wb_busy  = Bank_Full[Wr_Bank] && !(release_rd && rd_bank == Wr_Bank);
  assign refuse   = sw_rise && len_eff != '0 && wb_busy;
  assign commit   = sw_rise && len_eff != '0 && !wb_busy;
  assign nxt      = idx + LW'(1);
  // prefetch on acceptance keeps one sample per cycle; pad positions are never read
  assign rd_en    = state == FETCH || (accept && !rd_last && nxt < rd_len);
  assign rd_ma    = (state == FETCH ? '0 : nxt) + (rd_bank ? DEP : '0);

  assign bus.Rd_Valid = rd_valid;
  assign bus.Rd_I     = (rd_valid && !pad_q) ? rdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign bus.Rd_Q     = (rd_valid && !pad_q) ? rdata[DATA_WIDTH-1:0] : '0;
  assign bus.Rd_Index = idx[ADDR_WIDTH-1:0];
  assign bus.Rd_First = rd_first;
  assign bus.Rd_Last  = rd_last;

  always_ff @(posedge CLK_PP) begin
    if (wr_store) mem[wr_ma] <= {bus.Wr_I, bus.Wr_Q};
    if (rd_en) rdata <= mem[rd_ma];
  end

  always_ff @(posedge CLK_PP or negedge RST_PP) begin
    if (!RST_PP) begin
      state        <= IDLE;
      sw_q         <= 1'b0;
      Wr_Bank      <= 1'b0;
      Bank_Full    <= 2'b00;
      Overflow     <= 1'b0;
      Addr_Err     <= 1'b0;
      wr_len       <= '0;
      frame_len[0] <= '0;
      frame_len[1] <= '0;
      rd_len       <= '0;
      rd_end       <= '0;
      idx          <= '0;
      rd_bank      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_first     <= 1'b0;
      rd_last      <= 1'b0;
      pad_q        <= 1'b0;
    end else begin
      sw_q      <= bus.PINGPONG_SWITCH;
      Addr_Err  <= Addr_Err || (bus.write_enable && !wr_ok);
      Overflow  <= Overflow || refuse;
      wr_len    <= sw_rise ? '0 : len_eff;
      Bank_Full <= (Bank_Full & ~({1'b0, release_rd} << rd_bank)) | ({1'b0, commit} << Wr_Bank);
      if (commit) begin
        frame_len[Wr_Bank] <= len_eff;
        Wr_Bank            <= !Wr_Bank;
      end
      case (state)
        IDLE: begin
          rd_len <= frame_len[rd_bank];
          rd_end <= round12(frame_len[rd_bank]);
          state  <= Bank_Full[rd_bank] ? FETCH : IDLE;
        end
        FETCH: begin
          state    <= STREAM;
          rd_valid <= 1'b1;
          idx      <= '0;
          rd_first <= 1'b1;
          rd_last  <= rd_end == LW'(1);
          pad_q    <= 1'b0;
        end
        STREAM: begin
          if (accept && rd_last) begin
            rd_valid <= 1'b0;
            rd_bank  <= !rd_bank;
            state    <= IDLE;
          end else if (accept) begin
            idx      <= nxt;
            rd_first <= 1'b0;
            rd_last  <= nxt == rd_end - LW'(1);
            pad_q    <= nxt >= rd_len;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
